// File: rtl/conv_window_mac_pkg.sv
// Shared constants, state encoding and element-unpacking helper for the
// weight-stationary convolution MAC stage.
package conv_window_mac_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int WS_DEPTH   = 5;
  localparam int WS_WIDTH   = 40;
  localparam int ACC_WIDTH  = 32;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  typedef logic [1:0] mac_state_t;

  localparam mac_state_t ST_IDLE  = 2'd0;
  localparam mac_state_t ST_MAC   = 2'd1;
  localparam mac_state_t ST_DRAIN = 2'd2;
  localparam mac_state_t ST_OUT   = 2'd3;

  typedef logic signed [DATA_WIDTH-1:0]        elem_t;
  typedef logic [WS_DEPTH-1:0][WS_WIDTH-1:0]   ws_rows_t;

  // Column 0 is the MSB byte of the row.
  function automatic elem_t get_elem(input logic [WS_WIDTH-1:0] row, input logic [2:0] col);
    elem_t e;
    e = '0;
    for (int j = 0; j < WS_DEPTH; j++) begin
      if (int'(col) == j) e = row[WS_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH];
    end
    return e;
  endfunction

endpackage

// File: rtl/conv_window_mac_if.sv
// Weight store, activation, bias and result handshake bundle for conv_window_mac.
interface conv_window_mac_if;
  import conv_window_mac_pkg::*;

  logic                 ws_full;
  logic                 ws_invalidate;
  ws_rows_t             ws_rd_data;
  logic [3:0]           param_r;
  logic [3:0]           param_s;
  logic                 act_valid;
  logic                 act_ready;
  ws_rows_t             act_data;
  logic [ACC_WIDTH-1:0] bias;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 busy;
  logic                 param_err;

  modport master (
    output ws_full, ws_invalidate, ws_rd_data, param_r, param_s,
    output act_valid, act_data, bias, out_ready,
    input  act_ready, out_valid, out_data, busy, param_err
  );

  modport slave (
    input  ws_full, ws_invalidate, ws_rd_data, param_r, param_s,
    input  act_valid, act_data, bias, out_ready,
    output act_ready, out_valid, out_data, busy, param_err
  );

endinterface

// File: rtl/conv_window_mac_col_unit.sv
// One kernel column per cycle: five signed int8 products, rows >= R masked,
// summed and registered (1-cycle latency, valid travels alongside).
module conv_window_mac_col_unit
  import conv_window_mac_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic [3:0]                 r_i,
  input  elem_t [WS_DEPTH-1:0]       w_i,
  input  elem_t [WS_DEPTH-1:0]       a_i,
  output logic                       valid_o,
  output logic [ACC_WIDTH-1:0]       sum_o
);

  logic signed [PROD_WIDTH-1:0] prod [WS_DEPTH];
  logic signed [ACC_WIDTH-1:0]  sum_d;
  logic [ACC_WIDTH-1:0]         sum_q;
  logic                         valid_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < WS_DEPTH; i++) begin
      prod[i] = $signed(w_i[i]) * $signed(a_i[i]);
      if (i >= int'(r_i)) prod[i] = '0;
      sum_d = sum_d + ACC_WIDTH'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_i;
      sum_q   <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/conv_window_mac.sv
// Weight-stationary convolution MAC: captures one RxS window plus weights,
// accumulates one column per cycle onto BIAS and returns the 32b dot product.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | waiting for weights-ready and a valid window
//  ST_MAC   | issuing columns 0..S-1 to the column unit
//  ST_DRAIN | column pipeline and accumulator settling
//  ST_OUT   | result presented, held until out_ready
module conv_window_mac
  import conv_window_mac_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  conv_window_mac_if.slave   bus
);

  mac_state_t           state_q, state_d;
  logic                 ws_rdy_q;
  logic                 param_err_q;
  ws_rows_t             w_q, a_q;
  logic [3:0]           r_q, s_q;
  logic [2:0]           col_q;
  logic [1:0]           drain_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q;

  logic                 params_ok, accept, last_col, drain_done;
  elem_t [WS_DEPTH-1:0] w_col, a_col;
  logic                 col_valid;
  logic [ACC_WIDTH-1:0] col_sum;

  assign params_ok = (bus.param_r >= 4'd1) && (bus.param_r <= 4'(WS_DEPTH)) &&
                     (bus.param_s >= 4'd1) && (bus.param_s <= 4'(WS_DEPTH));
  assign bus.act_ready = (state_q == ST_IDLE) && ws_rdy_q && params_ok;
  assign accept        = bus.act_valid && bus.act_ready;
  assign last_col      = (col_q == 3'(s_q - 4'd1));
  // Three settle cycles put OUT_VALID at accept + S + 3.
  assign drain_done    = (drain_q == 2'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)        state_d = ST_MAC;
      ST_MAC:   if (last_col)      state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)    state_d = ST_OUT;
      ST_OUT:   if (bus.out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (accept)         acc_d = bus.bias;
    else if (col_valid) acc_d = acc_q + col_sum;
  end

  always_comb begin
    for (int i = 0; i < WS_DEPTH; i++) begin
      w_col[i] = get_elem(w_q[i], col_q);
      a_col[i] = get_elem(a_q[i], col_q);
    end
  end

  conv_window_mac_col_unit u_col (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (state_q == ST_MAC),
    .r_i     (r_q),
    .w_i     (w_col),
    .a_i     (a_col),
    .valid_o (col_valid),
    .sum_o   (col_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ws_rdy_q    <= 1'b0;
      param_err_q <= 1'b0;
      w_q         <= '0;
      a_q         <= '0;
      r_q         <= '0;
      s_q         <= '0;
      col_q       <= '0;
      drain_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;

      if (bus.ws_invalidate)  ws_rdy_q <= 1'b0;
      else if (bus.ws_full)   ws_rdy_q <= 1'b1;

      if ((state_q == ST_IDLE) && bus.act_valid && !params_ok) param_err_q <= 1'b1;

      if (accept) begin
        w_q <= bus.ws_rd_data;
        a_q <= bus.act_data;
        r_q <= bus.param_r;
        s_q <= bus.param_s;
      end

      if (accept)                                col_q <= '0;
      else if ((state_q == ST_MAC) && !last_col) col_q <= col_q + 3'd1;

      if (state_q == ST_DRAIN) drain_q <= drain_q + 2'd1;
      else                     drain_q <= '0;

      acc_q <= acc_d;

      if ((state_q == ST_DRAIN) && drain_done) out_data_q <= acc_q;
    end
  end

  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.param_err = param_err_q;

endmodule
